// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity codes and the baud divisor helper.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t S_IDLE   = 3'd0;
  localparam uart_state_t S_START  = 3'd1;
  localparam uart_state_t S_DATA   = 3'd2;
  localparam uart_state_t S_PARITY = 3'd3;
  localparam uart_state_t S_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per bit period; integer division, remainder dropped.
  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with head-of-queue visible on rdata.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: byte FIFO feeding an 8-bit shifter that frames
// start / 8 data (LSB first) / optional parity / stop onto hc05_tx.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 24000000,
  parameter int UART_BPS   = 9600,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY     = PARITY_NONE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_vld,
  output logic                          tx_rdy,
  output logic                          hc05_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output uart_state_t                   state_dbg
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int BW      = $clog2(BPS_CNT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BPS_CNT - 1);

  // Handshake: a byte is taken on any rising edge where tx_vld && tx_rdy;
  // the producer must hold tx_data stable while tx_vld is high and tx_rdy low.

  uart_state_t state;
  uart_state_t state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          tx_q;
  logic          tx_nxt;
  logic          bit_end;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_vld),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign tx_rdy    = !fifo_full;
  assign tx_busy   = (state != S_IDLE) || !fifo_empty;
  assign hc05_tx   = tx_q;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!fifo_empty) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && bit_cnt == 3'd7)
                  state_nxt = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (bit_end) state_nxt = fifo_empty ? S_IDLE : S_START;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Line value for the next clock; the shifter is already one bit ahead in DATA,
  // so the upcoming data bit is shift[1].
  always_comb begin
    fifo_pop = 1'b0;
    tx_nxt   = tx_q;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          tx_nxt   = 1'b0;
        end
      end
      S_START:  if (bit_end) tx_nxt = shift[0];
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) tx_nxt = (PARITY != PARITY_NONE) ? par_bit : 1'b1;
          else                 tx_nxt = shift[1];
        end
      end
      S_PARITY: if (bit_end) tx_nxt = 1'b1;
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            tx_nxt   = 1'b0;
          end else begin
            tx_nxt   = 1'b1;
          end
        end
      end
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_q <= tx_nxt;
      if (fifo_pop) begin
        shift    <= fifo_head;
        par_bit  <= (PARITY == PARITY_ODD) ? ~^fifo_head : ^fifo_head;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != S_IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
        if (bit_end && state == S_DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule
